// File: rtl/max7219_display.sv
// MAX7219 daisy-chain refresher: re-sends the 13-command init+digit list forever.
// One pass is exactly 13 * (32*CLK_DIV*NUM_CASCADES + 3*CLK_DIV + 1) clks.

module max7219_word (
  input  logic [3:0]      cmd_i,
  input  logic [3:0]      addr_i,
  input  logic [7:0]      cfg_i,
  input  logic [3:0][7:0] bytes_i,
  output logic [15:0]     word_o
);
  logic [2:0] row;
  logic [7:0] data;

  // Digit rows 1,3,5,7 carry frame bytes 0..3; even rows are blank spacers.
  always_comb begin
    row  = 3'(cmd_i - 4'd4);
    data = cfg_i;
    if (cmd_i >= 4'd5) data = row[0] ? bytes_i[row[2:1]] : 8'h00;
  end

  assign word_o = {4'h0, addr_i, data};
endmodule

module max7219_display #(
  parameter int NUM_CASCADES = 1,
  parameter int INTENSITY    = 1,
  parameter int CLK_DIV      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  frame [4*NUM_CASCADES],
  output logic        spi_clk,
  output logic        dout,
  output logic        cs,
  output logic        stop,
  output logic [10:1] pin
);
  localparam int NB = 4 * NUM_CASCADES;
  localparam int SW = 16 * NUM_CASCADES;
  localparam int BW = $clog2(SW);
  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] PH_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SW - 1);
  localparam logic [3:0]    INT4     = 4'(INTENSITY);
  localparam logic [3:0]    CMD_LAST = 4'd12;

  typedef enum logic [2:0] {S_GAP, S_LOAD, S_LOW, S_HIGH, S_TAIL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [SW-1:0] sreg_q, sreg_d;
  logic          stop_q, stop_d;
  logic          alive_q;
  logic          load_shadow;
  logic          cnt_done;
  logic [7:0]    shadow_q [NB];
  logic [3:0]    addr;
  logic [7:0]    cfg_data;
  logic [NUM_CASCADES-1:0][15:0] words;

  always_comb begin
    addr     = 4'(cmd_q - 4'd4);
    cfg_data = 8'h00;
    case (cmd_q)
      4'd0: begin addr = 4'hC; cfg_data = 8'h01; end
      4'd1: begin addr = 4'h9; cfg_data = 8'h00; end
      4'd2: begin addr = 4'hB; cfg_data = 8'h07; end
      4'd3: begin addr = 4'hA; cfg_data = {4'h0, INT4}; end
      4'd4: begin addr = 4'hF; cfg_data = 8'h00; end
      default: ;
    endcase
  end

  // Device NUM_CASCADES-1 lands in the MSBs so it is shifted out first.
  for (genvar d = 0; d < NUM_CASCADES; d++) begin : g_dev
    max7219_word u_word (
      .cmd_i   (cmd_q),
      .addr_i  (addr),
      .cfg_i   (cfg_data),
      .bytes_i ({shadow_q[4*d+3], shadow_q[4*d+2], shadow_q[4*d+1], shadow_q[4*d]}),
      .word_o  (words[d])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_GAP;
      cnt_q   <= '0;
      bit_q   <= '0;
      cmd_q   <= '0;
      sreg_q  <= '0;
      stop_q  <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      sreg_q  <= sreg_d;
      stop_q  <= stop_d;
      alive_q <= 1'b1;
    end
  end

  // Frame is captured once per pass, on the same edge that drops cs for command 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NB; i++) shadow_q[i] <= 8'h00;
    end else if (load_shadow) begin
      for (int i = 0; i < NB; i++) shadow_q[i] <= frame[i];
    end
  end

  assign cnt_done = (cnt_q == ((state_q == S_GAP) ? GAP_LAST : PH_LAST));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    cmd_d       = cmd_q;
    sreg_d      = sreg_q;
    stop_d      = 1'b0;
    load_shadow = 1'b0;
    case (state_q)
      S_GAP: if (cnt_done) begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      S_LOAD: begin
        state_d     = S_LOW;
        cnt_d       = '0;
        bit_d       = '0;
        sreg_d      = words;
        load_shadow = (cmd_q == 4'd0);
      end
      S_LOW: if (cnt_done) begin
        state_d = S_HIGH;
        cnt_d   = '0;
      end
      S_HIGH: if (cnt_done) begin
        cnt_d = '0;
        if (bit_q == BIT_LAST) begin
          state_d = S_TAIL;
        end else begin
          state_d = S_LOW;
          bit_d   = bit_q + 1'b1;
          sreg_d  = sreg_q << 1;
        end
      end
      S_TAIL: if (cnt_done) begin
        state_d = S_GAP;
        cnt_d   = '0;
        stop_d  = (cmd_q == CMD_LAST);
        cmd_d   = (cmd_q == CMD_LAST) ? 4'd0 : cmd_q + 4'd1;
      end
      default: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
    endcase
  end

  // Debug header stays quiet until the first clk after reset release.
  always_comb begin
    spi_clk = 1'b0;
    cs      = 1'b1;
    dout    = 1'b0;
    case (state_q)
      S_LOW:  begin cs = 1'b0; dout = sreg_q[SW-1]; end
      S_HIGH: begin cs = 1'b0; dout = sreg_q[SW-1]; spi_clk = 1'b1; end
      S_TAIL: begin cs = 1'b0; dout = sreg_q[SW-1]; end
      default: ;
    endcase
    stop = stop_q;
    pin  = alive_q ? {2'b00, addr, stop_q, cs, dout, spi_clk} : 10'h000;
  end
endmodule

// File: tb/tb_max7219_display.sv
// Bench for max7219_display: SPI window decoder feeding a scoreboard, plus vector table.

module tb_max7219_display;
  localparam int NC  = 2;
  localparam int CD  = 2;
  localparam int INT = 5;
  localparam int PASS_CLKS = 13 * (1 + 2*CD*16*NC + CD + 2*CD);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  frame [4*NC];
  logic        spi_clk, dout, cs, stop;
  logic [10:1] pin;

  max7219_display #(.NUM_CASCADES(NC), .INTENSITY(INT), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .frame(frame), .spi_clk(spi_clk),
    .dout(dout), .cs(cs), .stop(stop), .pin(pin)
  );

  always #5 clk = ~clk;

  int npass = 0, ntot = 0;
  int cyc = 0;
  logic [31:0] exp_q [$];
  logic [31:0] win_log [$];
  int stop_cyc [$];
  int wcnt = 0, nb = 0, hi_len = 0, hi_bad = 0, idle_bad = 0, stop_wide = 0, stop_cnt = 0;
  logic [31:0] bits = '0;
  logic prev_cs = 1'b1, prev_spi = 1'b0, prev_stop = 1'b0;

  localparam logic [63:0] F_OLD = 64'h8877665544332211;
  localparam logic [63:0] F_NEW = 64'hA7A6A5A4A3A2A1A0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    ntot++;
    if (got === want) npass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  function automatic logic [3:0] addr_of(input int c);
    case (c)
      0: return 4'hC;
      1: return 4'h9;
      2: return 4'hB;
      3: return 4'hA;
      4: return 4'hF;
      default: return 4'(c - 4);
    endcase
  endfunction

  function automatic logic [15:0] mdl(input int c, input int dev, input logic [63:0] f);
    int r, idx;
    case (c)
      0: return 16'h0C01;
      1: return 16'h0900;
      2: return 16'h0B07;
      3: return {12'h0A0, 4'(INT)};
      4: return 16'h0F00;
      default: begin
        r = c - 4;
        if (r % 2 == 0) return {4'h0, 4'(r), 8'h00};
        idx = 4*dev + (r-1)/2;
        return {4'h0, 4'(r), f[8*idx +: 8]};
      end
    endcase
  endfunction

  task automatic push_pass(input logic [63:0] f);
    for (int c = 0; c < 13; c++) exp_q.push_back({mdl(c, 1, f), mdl(c, 0, f)});
  endtask

  task automatic set_frame(input logic [63:0] f);
    for (int i = 0; i < 4*NC; i++) frame[i] = f[8*i +: 8];
  endtask

  task automatic wait_wcnt(input int target);
    int n = 0;
    while (wcnt < target && n < 6000) begin @(negedge clk); n++; end
    check($sformatf("reach_win%0d", target), 64'(wcnt >= target), 64'd1);
  endtask

  always @(posedge clk) cyc++;

  // SPI decoder: one 32-bit window per cs-low interval, compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      nb = 0; bits = '0; prev_cs = 1'b1; prev_spi = 1'b0; hi_len = 0; prev_stop = 1'b0;
    end else begin
      if (cs && dout) idle_bad++;
      if (stop) begin
        stop_cnt++;
        stop_cyc.push_back(cyc);
        if (prev_stop) stop_wide++;
      end
      if (!cs) begin
        if (spi_clk && !prev_spi) begin
          bits = {bits[30:0], dout};
          nb++;
          hi_len = 1;
          if (nb == 5)
            check("pin_mirror", 64'(pin), 64'({2'b00, addr_of(wcnt % 13), stop, cs, dout, spi_clk}));
        end else if (spi_clk) hi_len++;
        if (!spi_clk && prev_spi && hi_len != CD) hi_bad++;
      end
      if (cs && !prev_cs) begin
        win_log.push_back(bits);
        check("nbits", 64'(nb), 64'd32);
        check("stop_at_rise", 64'(stop), 64'(wcnt % 13 == 12));
        if (exp_q.size() == 0) begin
          ntot++;
          $display("FAIL sb_window%0d: got %h want nothing queued", wcnt, bits);
        end else begin
          check($sformatf("sb_window%0d", wcnt), 64'(bits), 64'(exp_q.pop_front()));
        end
        wcnt++;
        nb = 0;
        bits = '0;
      end
      prev_cs = cs; prev_spi = spi_clk; prev_stop = stop;
    end
  end

  typedef struct {
    string       name;
    int          win;
    logic [31:0] want;
  } vec_t;

  initial begin
    vec_t vt [5];
    int n;
    vt[0] = '{"cmd0_normal", 0, 32'h0C01_0C01};
    vt[1] = '{"intensity",   3, 32'h0A05_0A05};
    vt[2] = '{"digit1",      5, 32'h0155_0111};
    vt[3] = '{"digit2",      6, 32'h0200_0200};
    vt[4] = '{"digit7",     11, 32'h0788_0744};

    set_frame(64'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      frame[k] = 8'($urandom);
    end
    @(negedge clk);
    check("rst_cs", 64'(cs), 64'd1);
    check("rst_spi_clk", 64'(spi_clk), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_stop", 64'(stop), 64'd0);
    check("rst_pin", 64'(pin), 64'd0);

    set_frame(F_OLD);
    push_pass(F_OLD);
    push_pass(F_OLD);
    reset = 1'b1;
    n = 0;
    while (cs && n < 20) begin @(negedge clk); n++; end
    check("first_cs_fall", 64'(n <= 2*CD + 2), 64'd1);

    wait_wcnt(13);
    for (int i = 0; i < 5; i++)
      check(vt[i].name, 64'(win_log[vt[i].win]), 64'(vt[i].want));

    // Change the frame while digit 3 of the second pass is shifting.
    n = 0;
    while (!(wcnt == 20 && !cs && nb >= 3) && n < 4000) begin @(negedge clk); n++; end
    check("reach_digit3", 64'(wcnt), 64'd20);
    set_frame(F_NEW);
    push_pass(F_NEW);

    wait_wcnt(39);
    check("stop_count3", 64'(stop_cnt), 64'd3);
    check("pass_len", 64'(stop_cyc[1] - stop_cyc[0]), 64'(PASS_CLKS));
    check("pass3_digit1", 64'(win_log[31]), 64'hA4A4_A0A0 & 64'h0 | 64'h01A4_01A0);

    // Abort during bit 10 of the next command.
    n = 0;
    while (!(!cs && nb == 10) && n < 4000) begin @(negedge clk); n++; end
    check("reach_bit10", 64'(nb), 64'd10);
    #2 reset = 1'b0;
    #1;
    check("async_cs", 64'(cs), 64'd1);
    check("async_spi_clk", 64'(spi_clk), 64'd0);
    exp_q.delete();
    push_pass(F_NEW);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    wait_wcnt(52);
    check("post_rst_cmd0", 64'(win_log[39]), 64'h0C01_0C01);
    check("stop_count4", 64'(stop_cnt), 64'd4);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("high_phase_len", 64'(hi_bad), 64'd0);
    check("dout_idle_low", 64'(idle_bad), 64'd0);
    check("stop_width", 64'(stop_wide), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/max7219_display.md
Name: max7219_display

Overview:
- Drives a daisy-chain of NUM_CASCADES MAX7219 8x8 LED matrix controllers over a 3-wire serial link (clock, data, load/CS).
- Displays a byte array supplied by the parent as LED bit patterns.
- Sits at the top level, fed from a free-running system clock, and continuously re-initialises and refreshes the chain.
- Also exposes status and debug outputs for a logic-analyser header.

Parameters:
- NUM_CASCADES, default 1: number of chained MAX7219 devices; frame holds 4*NUM_CASCADES bytes.
- INTENSITY, default 1: brightness value 0..15 written to register 0x0A.
- CLK_DIV, default 4: spi_clk half-period in clk cycles; must be >= 1.

Ports:
- clk  in  1: system clock; all logic on its rising edge.
- reset  in  1: asynchronous, active-low reset.
- frame  in  8 x (4*NUM_CASCADES): unpacked byte array, element i is 8 bits.
- spi_clk  out  1: MAX7219 CLK.
- dout  out  1: MAX7219 DIN, MSB first.
- cs  out  1: MAX7219 LOAD/CS; low while shifting, rising edge latches.
- stop  out  1: one-clk pulse at end of each full refresh pass.
- pin  out  10 (pin[10:1]): debug mirror.

Behaviour:
- Reset (reset=0, async): spi_clk=0, dout=0, cs=1, stop=0, pin=0.
  - Sequencer returns to command 0.
  - Reset mid-transfer aborts immediately; no partial latch can occur because cs is forced high and the chain is re-initialised afterwards.
- Word format: 16 bits {4'h0, addr[3:0], data[7:0]}, sent MSB first.
- Command: one cs-low window shifting NUM_CASCADES words, i.e. 16*NUM_CASCADES bits.
  - The word for device NUM_CASCADES-1 (farthest from dout) is shifted first.
  - The word for device 0 is shifted last.
- Command list for one pass (13 commands, fixed order):
  - 0x0C=0x01 (normal operation)
  - 0x09=0x00 (no decode)
  - 0x0B=0x07 (scan all rows)
  - 0x0A=INTENSITY[3:0]
  - 0x0F=0x00 (test off)
  - digits 0x01..0x08
- Config commands send the same word to every device.
- Digit data for device d, register r (1..8):
  - r odd: frame[4d + (r-1)/2].
  - r even: 0x00 (blank spacer row).
- Frame sampling: all frame bytes are sampled into an internal shadow at the start of each pass (command 0, cs falling). A pass is never torn by frame changes.
- Bit timing per command:
  - cs falls with spi_clk=0 and dout = first bit.
  - Each bit: spi_clk low for CLK_DIV clks, then high for CLK_DIV clks. dout changes only on the clk where spi_clk goes low, or at cs fall for the first bit.
  - After the last high phase: spi_clk=0 for CLK_DIV clks, then cs rises.
  - cs stays high for 2*CLK_DIV clks before the next command.
  - dout=0 whenever cs=1.
- Pass end: after command 12's cs rise, stop=1 for exactly one clk. The next pass (command 0) starts after the normal 2*CLK_DIV gap. Refresh is continuous.
- Idle levels: spi_clk low between commands; cs high only between commands.
- pin mapping:
  - pin[1]=spi_clk, pin[2]=dout, pin[3]=cs, pin[4]=stop
  - pin[8:5]=address nibble of current command
  - pin[10:9]=0
- Pass length in clks: 13 * (1 + 2*CLK_DIV*16*NUM_CASCADES + CLK_DIV + 2*CLK_DIV), ±1 for state-transition clks. The implementation must be internally consistent and document the exact figure.

Test Plan:
- Reset: hold reset=0 for 5 clks, toggle frame → cs=1, spi_clk=0, dout=0, stop=0, pin=0. After release, first cs fall occurs within 2*CLK_DIV+2 clks.
- First command (NUM_CASCADES=2, CLK_DIV=2) → exactly 32 spi_clk rising edges while cs=0. The sampled bits equal 0x0C01 twice, and each high phase lasts 2 clks.
- Intensity (INTENSITY=5) → 4th cs window carries 0x0A05 per device.
- Digit mapping (NUM_CASCADES=2, frame = 0x11,0x22,...,0x88):
  - Digit-1 window sends 0x0155 then 0x0111, i.e. device 1 word first.
  - Digit-2 window sends 0x0200 twice.
  - Digit-7 window sends 0x0788 then 0x0744.
- Frame change mid-pass: change frame during digit 3 → remainder of the pass uses old values; the next pass uses new values.
- Reset mid-shift: assert reset during bit 10 → cs goes high asynchronously. After release, the first command is again 0x0C01, and stop pulses once per completed pass only.
